// File: rtl/shared_counter_n_if.sv
// Bus bundle for shared_counter_n: per-port write lanes/requests, count enable,
// and the stored value with its status pulses.
interface shared_counter_n_if #(
  parameter int WIDTH  = 9,
  parameter int NPORTS = 2
);
  localparam int OW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [NPORTS*WIDTH-1:0] wrdata;
  logic [NPORTS-1:0]       wr;
  logic                    inc;
  logic [WIDTH-1:0]        value;
  logic                    busy;
  logic [OW-1:0]           owner;
  logic                    done;
  logic                    wrap;

  modport master (output wrdata, wr, inc, input value, busy, owner, done, wrap);
  modport slave  (input wrdata, wr, inc, output value, busy, owner, done, wrap);
endinterface

// File: rtl/shared_counter_n.sv
// Shared counter with NPORTS writers: a granted port holds the block until it drops wr.
// Define SHARED_COUNTER_RR_EN for round-robin grants; default is fixed lowest-index priority.
module shared_counter_lane #(
  parameter int WIDTH = 9
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] masked
);
  assign masked = sel ? data : '0;
endmodule

module shared_counter_n #(
  parameter int WIDTH  = 9,
  parameter int NPORTS = 2
) (
  input logic clk,
  input logic rst,
  shared_counter_n_if.slave bus
);
  localparam int OW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                        state, state_nx;
  logic [WIDTH-1:0]              value_q, value_nx, hold_q, hold_nx, cap;
  logic [OW-1:0]                 owner_q, owner_nx, grant;
  logic                          done_q, done_nx, wrap_q, wrap_nx;
  logic [NPORTS-1:0]             gnt_oh;
  logic [NPORTS-1:0][WIDTH-1:0]  lane_in, lane_out;

  assign lane_in = bus.wrdata;

`ifdef SHARED_COUNTER_RR_EN
  logic [OW-1:0] rr_ptr;

  // Walk from farthest to nearest so the port right after rr_ptr wins.
  always_comb begin
    grant = '0;
    for (int k = NPORTS; k >= 1; k--)
      if (bus.wr[(int'(rr_ptr) + k) % NPORTS]) grant = OW'((int'(rr_ptr) + k) % NPORTS);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= OW'(NPORTS - 1);
    else if (state == IDLE && |bus.wr) rr_ptr <= grant;
`else
  always_comb begin
    grant = '0;
    for (int i = NPORTS - 1; i >= 0; i--)
      if (bus.wr[i]) grant = OW'(i);
  end
`endif

  always_comb
    for (int i = 0; i < NPORTS; i++) gnt_oh[i] = (grant == OW'(i));

  genvar g;
  generate
    for (g = 0; g < NPORTS; g++) begin : g_lane
      shared_counter_lane #(.WIDTH(WIDTH)) u_lane (
        .sel    (gnt_oh[g]),
        .data   (lane_in[g]),
        .masked (lane_out[g])
      );
    end
  endgenerate

  always_comb begin
    cap = '0;
    for (int i = 0; i < NPORTS; i++) cap = cap | lane_out[i];
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      value_q <= '0;
      hold_q  <= '0;
      owner_q <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      value_q <= value_nx;
      hold_q  <= hold_nx;
      owner_q <= owner_nx;
      done_q  <= done_nx;
      wrap_q  <= wrap_nx;
    end

  // Writes beat inc; inc is simply lost while any request or ownership exists.
  always_comb begin
    state_nx = state;
    value_nx = value_q;
    hold_nx  = hold_q;
    owner_nx = owner_q;
    done_nx  = 1'b0;
    wrap_nx  = 1'b0;
    case (state)
      IDLE:
        if (|bus.wr) begin
          hold_nx  = cap;
          owner_nx = grant;
          state_nx = HOLD;
        end else if (bus.inc) begin
          value_nx = value_q + 1'b1;
          wrap_nx  = &value_q;
        end
      HOLD:
        if (!bus.wr[owner_q]) begin
          value_nx = hold_q;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
    endcase
  end

  assign bus.value = value_q;
  assign bus.busy  = (state == HOLD);
  assign bus.owner = owner_q;
  assign bus.done  = done_q;
  assign bus.wrap  = wrap_q;
endmodule
